interrupt_controller: RTL
=========================

# interrupt_controller

Level-sensitive external interrupt controller that sits directly upstream of the core's `ext_int` input. It gathers up to 31 device interrupt lines, synchronizes and latches them as pending, and applies a per-source enable mask. It presents a single active-high `ext_int` to the core and exposes a small word-addressed register port. Software uses that port to enable sources, claim the lowest-numbered pending source, and signal completion.

## Interface
Parameters:
- `NUM_SOURCES`, 8: number of interrupt sources, legal range 1..31; source IDs are 1..`NUM_SOURCES`, ID 0 means "none".

Ports:
- `clk` input 1: system clock, all state on posedge.
- `reset_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `src` input `NUM_SOURCES`: device interrupt lines, level-high; `src[i]` is ID i+1.
- `enable_n` input 1: register access strobe, active low; one access per cycle while low.
- `is_write` input 1: 1 = write, 0 = read; valid while `enable_n` is low.
- `addr` input 4: byte offset; `addr[3:2]` selects the register.
- `in` input 32: write data.
- `out` output 32: read data. Combinational during the access cycle; 0 when `enable_n` is high.
- `addr_fault` output 1: high when `enable_n` is low and `addr[1:0]` != 0; that access has no effect.
- `ext_int` output 1: interrupt request to the core.

## Operation
- Registers, selected by `addr[3:2]`:
  - 0 PENDING: read-only; bit i is pending for ID i+1. Writes are ignored.
  - 1 ENABLE: read/write; bits ≥ `NUM_SOURCES` read 0.
  - 2 CLAIM/COMPLETE: see claim and complete below.
  - 3: reserved; reads 0, writes ignored.
- Per-source state: `pending`, `in_service`.
- Setting pending: `pending` sets when the synchronized src is high, `pending`=0, and `in_service`=0.
- Claim (read of reg 2):
  - `out` = {27'b0, ID}, where ID is the lowest ID with `pending & enable`, or 0 if none.
  - At the closing posedge, that source gets `pending`←0 and `in_service`←1.
  - A claim that returns 0 has no side effect.
- Complete (write of reg 2): `in[4:0]` = ID.
  - If that source's `in_service` is 1, it is cleared at the posedge.
  - ID 0, ID > `NUM_SOURCES`, or a source not in service: ignored.
- After complete, a still-high source re-pends on the following edge.
- `ext_int` = OR over sources of (`pending & enable`). Combinational from registers; no path from `src` or the bus.
- Disabling a source masks it from `ext_int` and from claim, but leaves `pending` set.
- Simultaneous events:
  - Claim of source k and src k still high at the same edge: `in_service` wins, `pending` stays 0.
  - Enable write and claim cannot co-occur (one access per cycle).
- A misaligned access (`addr_fault`) performs no claim and no write; `out` = 0.

## Timing
- Reset (asynchronous assert): `pending`, `enable`, `in_service`, and synchronizer flops all go to 0. Resulting outputs: `ext_int`=0, `out`=0, `addr_fault`=0 (strobe high).
- Reset release: the first active edge is the first posedge after `reset_n` rises.
- Latency with synchronizers (see Configuration): src rises before posedge N → `pending` set at edge N+2 → `ext_int` high after edge N+2 (3 edges).
- Latency without synchronizers: `pending` and `ext_int` follow at edge N.
- Claim: `ext_int` drops after the claim edge if no other enabled source is pending.
- Reset mid-claim: all claim and service state is discarded; no completion is required after reset.

## Configuration
- `INT_CTRL_SYNC_EN`:
  - Defined: each `src` bit passes through a 2-flop synchronizer before the gateway. Use for asynchronous devices.
  - Undefined: `src` is sampled directly. Devices must then be synchronous to `clk`; latency drops by 2 cycles.
  - Register map and all other behaviour are identical in both builds.

## Structure
- Package `int_ctrl_pkg` holds:
  - Register offset constants: `INT_REG_PENDING`=0, `INT_REG_ENABLE`=1, `INT_REG_CLAIM`=2.
  - `INT_ID_WIDTH`=5.
  - typedef `int_id_t` (logic [4:0]).
- Sub-module `int_gateway`, one instance per source:
  - Contains the optional synchronizer, `pending`, and `in_service`.
  - Inputs: `claim`, `complete` strobes from the top.
  - Outputs: `pending`, `in_service`.
- Top level holds: ENABLE register, lowest-ID priority encoder, bus decode, and `ext_int`.

## Test plan
- Reset, no stimulus: ENABLE=0x0, PENDING=0x0, claim returns 0, `ext_int`=0.
- src[2] high, ENABLE=0x04 (sync build): PENDING=0x04 and `ext_int`=1 at the 3rd edge. Claim returns 3, then PENDING=0x00 and `ext_int`=0. Write COMPLETE=3 with src still high: PENDING=0x04 one edge later.
- src[1] and src[5] high, ENABLE=0x22: first claim returns 2, second returns 6, third returns 0. Complete 2, then 6: both `in_service` bits clear.
- src[0] high, ENABLE=0: PENDING=0x01, `ext_int`=0, claim returns 0. Write ENABLE=0x01: `ext_int`=1 the next cycle.
- Illegal accesses:
  - Write COMPLETE=7 with nothing in service: no change.
  - Write COMPLETE=0 or 31: no change.
  - Access at addr 0x9: `addr_fault`=1, no claim.
- `reset_n` asserted mid-service (ID 4 claimed): all state 0 immediately. After release, src[3] still high re-pends without any complete.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register offsets, ID width and ID type shared by the interrupt controller.
package int_ctrl_pkg;
    localparam int INT_ID_WIDTH = 5;
    localparam logic [1:0] INT_REG_PENDING = 2'd0;
    localparam logic [1:0] INT_REG_ENABLE = 2'd1;
    localparam logic [1:0] INT_REG_CLAIM = 2'd2;
    typedef logic [INT_ID_WIDTH-1:0] int_id_t;
endpackage

// File: rtl/int_gateway.sv
// int_gateway: per-source pending/in-service state behind an optional src synchronizer.
// Build option INT_CTRL_SYNC_EN inserts a 2-flop synchronizer ahead of the pending logic.
module int_gateway (
    input  logic clk,
    input  logic reset_n,
    input  logic src_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pending_o,
    output logic in_service_o
);
    logic src_s, pending_q, pending_d, in_service_q, in_service_d;
`ifdef INT_CTRL_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) sync_q <= '0;
        else sync_q <= {sync_q[0], src_i};
    assign src_s = sync_q[1];
`else
    assign src_s = src_i;
`endif
    // claim beats a coincident src level; a source in service cannot re-pend until completed
    always_comb begin
        pending_d    = claim_i ? 1'b0 : pending_q | (src_s & ~in_service_q);
        in_service_d = claim_i | (in_service_q & ~complete_i);
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pending_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
        end
    assign pending_o = pending_q;
    assign in_service_o = in_service_q;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: level-sensitive external interrupt controller with ENABLE mask,
// lowest-ID claim/complete register port and a single ext_int request (see INT_CTRL_SYNC_EN).
module interrupt_controller
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SOURCES = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_SOURCES-1:0] src,
    input  logic                   enable_n,
    input  logic                   is_write,
    input  logic [3:0]             addr,
    input  logic [31:0]            in,
    output logic [31:0]            out,
    output logic                   addr_fault,
    output logic                   ext_int
);
    logic [NUM_SOURCES-1:0] enable_q, enable_d, pending, in_service, active, claim, complete;
    logic [1:0] sel;
    logic rd, wr, unused;
    int_id_t claim_id;
    assign sel = addr[3:2];
    assign addr_fault = ~enable_n & (addr[1:0] != 2'b00);
    assign rd = ~enable_n & ~addr_fault & ~is_write;
    assign wr = ~enable_n & ~addr_fault & is_write;
    assign active = pending & enable_q;
    assign ext_int = |active;
    assign unused = ^in;
    // scan downward so the lowest active ID is the last assignment
    always_comb begin
        claim_id = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--)
            if (active[i]) claim_id = int_id_t'(i + 1);
    end
    always_comb begin
        enable_d = (wr && sel == INT_REG_ENABLE) ? in[NUM_SOURCES-1:0] : enable_q;
        out = !rd ? '0 :
              sel == INT_REG_PENDING ? 32'(pending) :
              sel == INT_REG_ENABLE  ? 32'(enable_q) :
              sel == INT_REG_CLAIM   ? 32'(claim_id) : '0;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) enable_q <= '0;
        else enable_q <= enable_d;
    for (genvar g = 0; g < NUM_SOURCES; g++) begin : gw
        assign claim[g] = rd && sel == INT_REG_CLAIM && claim_id == int_id_t'(g + 1);
        assign complete[g] = wr && sel == INT_REG_CLAIM && in[INT_ID_WIDTH-1:0] == int_id_t'(g + 1)
                             && in_service[g];
        int_gateway u_gw (
            .clk         (clk),
            .reset_n     (reset_n),
            .src_i       (src[g]),
            .claim_i     (claim[g]),
            .complete_i  (complete[g]),
            .pending_o   (pending[g]),
            .in_service_o(in_service[g])
        );
    end
endmodule
